// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction encoder: opcodes, funct codes,
// request kinds and the single-word encoding function.
package isa_pkg;

  // Opcodes live in w[8:6]; ADDI owns both 000 and 001 because w[6] carries imm[6].
  localparam logic [2:0] OP_ADDI0 = 3'b000;
  localparam logic [2:0] OP_ADDI1 = 3'b001;
  localparam logic [2:0] OP_BR    = 3'b010;
  localparam logic [2:0] OP_MEM   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_ADD   = 3'b111;

  localparam logic [1:0] F_BEQ   = 2'b00;
  localparam logic [1:0] F_BLT   = 2'b01;
  localparam logic [1:0] F_BOV   = 2'b10;
  localparam logic [1:0] F_START = 2'b11;
  localparam logic [1:0] F_LDM   = 2'b00;
  localparam logic [1:0] F_LDL   = 2'b01;
  localparam logic [1:0] F_STB   = 2'b10;
  localparam logic [1:0] F_DONE  = 2'b11;

  // ADDI with imm = 64, used to build the upper half of LI8 values
  localparam logic [8:0] W_ADDI64  = {OP_ADDI1, 6'b000000};
  // XOR R0,R0 zeroes the accumulator register
  localparam logic [8:0] W_ZERO_R0 = {OP_XOR, 6'b000000};

  typedef enum logic [3:0] {
    K_ADD   = 4'd0,
    K_XOR   = 4'd1,
    K_AND   = 4'd2,
    K_SHL   = 4'd3,
    K_SHR   = 4'd4,
    K_ADDI  = 4'd5,
    K_BEQ   = 4'd6,
    K_BLT   = 4'd7,
    K_BOV   = 4'd8,
    K_LDM   = 4'd9,
    K_LDL   = 4'd10,
    K_STB   = 4'd11,
    K_START = 4'd12,
    K_DONE  = 4'd13,
    K_LI8   = 4'd14
  } kind_e;

  // Encoder FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  function automatic logic kind_defined(input logic [3:0] kind);
    return kind <= K_LI8;
  endfunction

  // First (or only) word of a request; LI8 starts with XOR R0,R0.
  function automatic logic [8:0] encode_word(input logic [3:0] kind,
                                             input logic [2:0] rd,
                                             input logic [2:0] rs,
                                             input logic [6:0] imm7);
    logic [8:0] w;
    w = 9'd0;
    case (kind)
      K_ADD:   w = {OP_ADD, rd, rs};
      K_XOR:   w = {OP_XOR, rd, rs};
      K_AND:   w = {OP_AND, rd, rs};
      K_SHL:   w = {OP_SHIFT, rd, rs[0], 1'b1, 1'b0};
      K_SHR:   w = {OP_SHIFT, rd, rs[0], 1'b0, 1'b0};
      K_ADDI:  w = {2'b00, imm7};
      K_BEQ:   w = {OP_BR, rs[1:0], rd[1:0], F_BEQ};
      K_BLT:   w = {OP_BR, rs[1:0], rd[1:0], F_BLT};
      K_BOV:   w = {OP_BR, rs[1:0], rd[1:0], F_BOV};
      K_START: w = {OP_BR, 4'b0000, F_START};
      K_LDM:   w = {OP_MEM, rs[1:0], rd[1:0], F_LDM};
      K_LDL:   w = {OP_MEM, rs[1:0], rd[1:0], F_LDL};
      K_STB:   w = {OP_MEM, rs[1:0], rd[1:0], F_STB};
      K_DONE:  w = {OP_MEM, 4'b0000, F_DONE};
      K_LI8:   w = W_ZERO_R0;
      default: w = 9'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/li8_sequencer.sv
// Step counter and word select for the LI8 expansion:
//   XOR R0,R0 ; ADDI imm[6:0] ; (imm[7] only) ADDI 64 ; ADDI 64
// The encoder issues step 0 itself at accept time, so a load points the
// counter at step 1.
module li8_sequencer
  import isa_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] imm,
  output logic [8:0] word,
  output logic       last
);

  logic [1:0] step;
  logic [7:0] imm_q;

  // Latch the immediate on load and walk the step counter as words issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step  <= 2'd0;
      imm_q <= 8'd0;
    end else if (clear) begin
      step  <= 2'd0;
    end else if (load) begin
      step  <= 2'd1;
      imm_q <= imm;
    end else if (advance) begin
      step  <= step + 2'd1;
    end
  end

  // Word for the current step and whether it ends the sequence
  always_comb begin
    word = W_ADDI64;
    case (step)
      2'd0:    word = W_ZERO_R0;
      2'd1:    word = {2'b00, imm_q[6:0]};
      default: word = W_ADDI64;
    endcase
    last = (step == 2'd3) || ((step == 2'd1) && !imm_q[7]);
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts one request per cycle, writes the
// encoded 9-bit word to instruction memory at an auto-incrementing address,
// and expands LI8 into a 2- or 4-word sequence.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready; single-word requests issue next cycle, LI8 starts expand
// EXPAND | not ready; issuing the remaining LI8 words one per cycle
// FULL   | memory exhausted by a write attempt; waits for clear or reset
module instr_encoder
  import isa_pkg::*;
#(
  parameter int AW = 8
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [2:0]    req_rd,
  input  logic [2:0]    req_rs,
  input  logic [7:0]    req_imm,
  input  logic          clear,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [8:0]    im_wdata,
  output logic [AW:0]   word_count,
  output logic          err_full,
  output logic          err_kind
);

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  logic [1:0] state;
  logic [1:0] state_n;
  logic       accept;
  logic       kind_ok;
  logic       is_li8;
  logic       at_cap;
  logic       issue;
  logic [8:0] issue_word;
  logic [8:0] req_word;
  logic [8:0] seq_word;
  logic       seq_last;
  logic       seq_load;
  logic       seq_adv;
  logic       set_full;
  logic       set_kind;

  // clear drops any request presented in the same cycle
  assign req_ready = (state == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;
  assign kind_ok   = kind_defined(req_kind);
  assign is_li8    = (req_kind == K_LI8);
  assign at_cap    = (word_count == CAP);
  assign req_word  = encode_word(req_kind, req_rd, req_rs, req_imm[6:0]);
  assign seq_load  = (state == ST_IDLE) && issue && is_li8;
  assign seq_adv   = (state == ST_EXPAND) && issue && !clear;

  li8_sequencer u_li8_seq (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .load    (seq_load),
    .advance (seq_adv),
    .imm     (req_imm),
    .word    (seq_word),
    .last    (seq_last)
  );

  // Next-state, write decision and error flags
  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_word = req_word;
    set_full   = 1'b0;
    set_kind   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!kind_ok) begin
            set_kind = 1'b1;
          end else if (at_cap) begin
            set_full = 1'b1;
            state_n  = ST_FULL;
          end else begin
            issue = 1'b1;
            if (is_li8) state_n = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (at_cap) begin
          set_full = 1'b1;
          state_n  = ST_FULL;
        end else begin
          issue      = 1'b1;
          issue_word = seq_word;
          if (seq_last) state_n = ST_IDLE;
        end
      end
      ST_FULL: state_n = ST_FULL;
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered memory write port, counters and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= 9'd0;
      word_count <= '0;
      err_full   <= 1'b0;
      err_kind   <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      im_we      <= 1'b0;
      im_addr    <= '0;
      word_count <= '0;
      err_full   <= 1'b0;
      err_kind   <= 1'b0;
    end else begin
      state <= state_n;
      im_we <= issue;
      if (issue) begin
        im_wdata   <= issue_word;
        im_addr    <= word_count[AW-1:0];
        word_count <= word_count + (AW+1)'(1);
      end
      if (set_full) err_full <= 1'b1;
      if (set_kind) err_kind <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of single-word encodings plus hand-written
// LI8, capacity, clear and reset sequences, checked through a write scoreboard.
module tb_instr_encoder;
  import isa_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic [2:0]    req_rd;
  logic [2:0]    req_rs;
  logic [7:0]    req_imm;
  logic          clear;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [8:0]    im_wdata;
  logic [AW:0]   word_count;
  logic          err_full;
  logic          err_kind;

  instr_encoder #(.AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_rd     (req_rd),
    .req_rs     (req_rs),
    .req_imm    (req_imm),
    .clear      (clear),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .word_count (word_count),
    .err_full   (err_full),
    .err_kind   (err_kind)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } exp_t;

  typedef struct {
    logic [3:0] kind;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
    logic [8:0] word;
  } vec_t;

  exp_t          sb[$];
  vec_t          vecs[15];
  int            checks = 0;
  int            errors = 0;
  int            writes = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] w);
    exp_t e;
    e.addr = exp_addr;
    e.data = w;
    sb.push_back(e);
    exp_addr = exp_addr + 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic drive(input logic [3:0] k, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [7:0] imm);
    int n;
    req_valid = 1'b1;
    req_kind  = k;
    req_rd    = rd;
    req_rs    = rs;
    req_imm   = imm;
    n = 0;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 for 50 cycles, expected ready=1");
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic count_ready_low(output int cnt);
    cnt = 0;
    #1;
    while (!req_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
      #1;
    end
  endtask

  // Write monitor: every im_we pulse must match the oldest expected write
  always @(posedge clk) begin
    #1;
    if (!reset && im_we) begin
      writes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 im_addr, im_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(im_addr), 32'(e.addr));
        check("wr_data", 32'(im_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    int cnt;
    int base;

    vecs[0]  = '{K_ADD,   3'd3, 3'd5, 8'h00, 9'h1DD};
    vecs[1]  = '{K_ADDI,  3'd0, 3'd0, 8'h25, 9'h025};
    vecs[2]  = '{K_SHL,   3'd2, 3'd1, 8'h00, 9'h116};
    vecs[3]  = '{K_BLT,   3'd2, 3'd1, 8'h00, 9'h099};
    vecs[4]  = '{K_XOR,   3'd7, 3'd0, 8'h00, 9'h1B8};
    vecs[5]  = '{K_AND,   3'd1, 3'd6, 8'h00, 9'h14E};
    vecs[6]  = '{K_SHR,   3'd5, 3'd2, 8'h00, 9'h128};
    vecs[7]  = '{K_ADDI,  3'd0, 3'd0, 8'hFF, 9'h07F};
    vecs[8]  = '{K_BEQ,   3'd0, 3'd3, 8'h00, 9'h0B0};
    vecs[9]  = '{K_BOV,   3'd3, 3'd2, 8'h00, 9'h0AE};
    vecs[10] = '{K_LDM,   3'd1, 3'd1, 8'h00, 9'h0D4};
    vecs[11] = '{K_LDL,   3'd3, 3'd0, 8'h00, 9'h0CD};
    vecs[12] = '{K_STB,   3'd6, 3'd3, 8'h00, 9'h0FA};
    vecs[13] = '{K_START, 3'd7, 3'd7, 8'hFF, 9'h083};
    vecs[14] = '{K_DONE,  3'd7, 3'd7, 8'hFF, 9'h0C3};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_kind  = 4'd0;
    req_rd    = 3'd0;
    req_rs    = 3'd0;
    req_imm   = 8'd0;
    clear     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_err_full", 32'(err_full), 32'd0);
    check("rst_err_kind", 32'(err_kind), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Table of single-word encodings issued back-to-back
    for (int i = 0; i < 15; i++) begin
      push(vecs[i].word);
      drive(vecs[i].kind, vecs[i].rd, vecs[i].rs, vecs[i].imm);
    end
    req_valid = 1'b0;
    drain();
    check("table_word_count", 32'(word_count), 32'd15);

    // Last address is writable, the next write attempt goes FULL
    push(9'h1C1);
    drive(K_ADD, 3'd0, 3'd1, 8'h00);
    req_valid = 1'b0;
    drain();
    check("last_addr", 32'(im_addr), 32'd15);
    check("cap_word_count", 32'(word_count), 32'd16);
    check("cap_no_err", 32'(err_full), 32'd0);
    drive(K_XOR, 3'd1, 3'd1, 8'h00);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("full_err", 32'(err_full), 32'd1);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_word_count", 32'(word_count), 32'd16);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    exp_addr = '0;
    check("clr_addr", 32'(im_addr), 32'd0);
    check("clr_word_count", 32'(word_count), 32'd0);
    check("clr_err_full", 32'(err_full), 32'd0);
    check("clr_ready", 32'(req_ready), 32'd1);

    // LI8 with imm[7] set: four words, ready low three cycles
    @(negedge clk);
    push(9'h180); push(9'h045); push(9'h040); push(9'h040);
    drive(K_LI8, 3'd0, 3'd0, 8'hC5);
    req_valid = 1'b0;
    count_ready_low(cnt);
    check("li8_c5_ready_low", 32'(cnt), 32'd3);
    drain();

    // LI8 with imm[7] clear: two words, ready low one cycle
    @(negedge clk);
    push(9'h180); push(9'h012);
    drive(K_LI8, 3'd0, 3'd0, 8'h12);
    req_valid = 1'b0;
    count_ready_low(cnt);
    check("li8_12_ready_low", 32'(cnt), 32'd1);
    drain();

    // Undefined kind: accepted, no write, sticky error
    @(negedge clk);
    drive(4'hF, 3'd1, 3'd2, 8'h00);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("undef_err_kind", 32'(err_kind), 32'd1);
    check("undef_ready", 32'(req_ready), 32'd1);
    check("undef_word_count", 32'(word_count), 32'd6);

    // clear wins over a simultaneous request
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = K_ADD;
    req_rd    = 3'd3;
    req_rs    = 3'd5;
    clear     = 1'b1;
    #1;
    check("clear_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    clear     = 1'b0;
    req_valid = 1'b0;
    #1;
    exp_addr = '0;
    check("clear_drop_count", 32'(word_count), 32'd0);
    check("clear_err_kind", 32'(err_kind), 32'd0);
    repeat (2) @(negedge clk);
    check("clear_drop_we", 32'(im_we), 32'd0);

    // LI8 crossing capacity: two words fit, then FULL
    for (int i = 0; i < 14; i++) begin
      push(9'(i));
      drive(K_ADDI, 3'd0, 3'd0, 8'(i));
    end
    req_valid = 1'b0;
    push(9'h180); push(9'h000);
    drive(K_LI8, 3'd0, 3'd0, 8'h80);
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    #1;
    check("li8_cap_err_full", 32'(err_full), 32'd1);
    check("li8_cap_word_count", 32'(word_count), 32'd16);
    check("li8_cap_ready", 32'(req_ready), 32'd0);
    check("li8_cap_addr", 32'(im_addr), 32'd15);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_addr = '0;

    // Reset in the middle of an LI8 expansion
    push(9'h180); push(9'h005); push(9'h040); push(9'h040);
    base = writes;
    drive(K_LI8, 3'd0, 3'd0, 8'h85);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_li8_writes", 32'(writes - base), 32'd2);
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_im_we", 32'(im_we), 32'd0);
    check("mid_rst_addr", 32'(im_addr), 32'd0);
    check("mid_rst_wdata", 32'(im_wdata), 32'd0);
    check("mid_rst_word_count", 32'(word_count), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_addr = '0;
    @(negedge clk);
    push(9'h1DD);
    drive(K_ADD, 3'd3, 3'd5, 8'h00);
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("post_rst_word_count", 32'(word_count), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
